// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory and its byte-stream loader.
package imem_pkg;

    // Processor fetch-address width (the core's native word size).
    localparam int unsigned BITNESS = 16;
    localparam int unsigned INS_W   = 16;

    localparam logic [INS_W-1:0] NOP_INS = 16'h0000;

    typedef enum logic [1:0] {
        StLoadLo = 2'd0,
        StLoadHi = 2'd1,
        StRun    = 2'd2
    } ld_state_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
module imem_ram #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned INS_W  = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [INS_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [INS_W-1:0]  rdata_o
);

    logic [INS_W-1:0] mem_q [DEPTH];

    // No reset: stale contents are hidden by the word-count mask in the loader.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a valid/ready byte loader; fetches read zero until the image is complete.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned INS_W  = imem_pkg::INS_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BITNESS-1:0] pc,
    output logic [INS_W-1:0]   ins,
    input  logic               ld_valid,
    input  logic [7:0]         ld_byte,
    input  logic               ld_last,
    output logic               ld_ready,
    input  logic               reload,
    output logic               run,
    output logic               ld_err,
    output logic [ADDR_W:0]    word_cnt
);

    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);

    ld_state_e         state_q, state_d;
    logic [7:0]        lo_q, lo_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              err_q, err_d;

    logic              beat;
    logic              mem_we;
    logic [INS_W-1:0]  mem_wdata;
    logic [INS_W-1:0]  mem_rdata;
    logic [ADDR_W-1:0] rd_idx;
    logic              unused_pc_hi;

    assign beat         = ld_valid & ld_ready;
    assign rd_idx       = pc[ADDR_W-1:0];
    assign unused_pc_hi = ^pc[BITNESS-1:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoadLo;
            lo_q       <= 8'h00;
            wr_addr_q  <= '0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            wr_addr_q  <= wr_addr_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        wr_addr_d  = wr_addr_q;
        word_cnt_d = word_cnt_q;
        err_d      = err_q;
        if (reload) begin
            // Restart wins over any beat presented in the same cycle.
            state_d    = StLoadLo;
            wr_addr_d  = '0;
            word_cnt_d = '0;
            err_d      = 1'b0;
        end else if (beat) begin
            unique case (state_q)
                StLoadLo: begin
                    lo_d = ld_byte;
                    if (ld_last) begin
                        word_cnt_d = word_cnt_q + CntOne;
                        err_d      = 1'b1;
                        state_d    = StRun;
                    end else begin
                        state_d = StLoadHi;
                    end
                end
                StLoadHi: begin
                    wr_addr_d  = wr_addr_q + AddrOne;
                    word_cnt_d = word_cnt_q + CntOne;
                    if (ld_last) begin
                        state_d = StRun;
                    end else if (wr_addr_q == AddrLast) begin
                        err_d   = 1'b1;
                        state_d = StRun;
                    end else begin
                        state_d = StLoadLo;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        ld_ready  = (state_q != StRun);
        run       = (state_q == StRun);
        ld_err    = err_q;
        word_cnt  = word_cnt_q;
        mem_we    = beat & ~reload &
                    ((state_q == StLoadHi) | ((state_q == StLoadLo) & ld_last));
        mem_wdata = (state_q == StLoadHi) ? {ld_byte, lo_q} : {8'h00, ld_byte};
        ins       = INS_W'(NOP_INS);
        if (run && ({1'b0, rd_idx} < word_cnt_q)) begin
            ins = mem_rdata;
        end
    end

    imem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .INS_W  (INS_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_addr_q),
        .wdata_i (mem_wdata),
        .raddr_i (rd_idx),
        .rdata_o (mem_rdata)
    );

endmodule
